// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response handshake and the word-RAM port for mem_access_unit.
// The master side is the pipeline plus RAM; the slave side is the access unit.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide RAM with one-cycle read latency.
// Define MEM_ACCESS_UNIT_SUBWORD_EN to enable byte/half loads and read-modify-write stores.
module mem_access_unit (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_RDW  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        accept_s;
    logic        req_err_s;
    logic        store_word_s;
    logic [31:0] load_data_s;
    logic [31:0] ram_addr_r;
    logic [31:0] ram_din_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;

`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
    logic        we_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [1:0]  lane_r;
    logic [15:0] wdata_r;

    // Lane 0 is the least significant byte; a half lane starts at byte 0 or 2.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [15:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            2'b00:   mask = 32'h0000_00FF << {lane, 3'b000};
            2'b01:   mask = 32'h0000_FFFF << {lane, 3'b000};
            default: mask = 32'h0000_0000;
        endcase
        ins = {16'h0000, wdata} << {lane, 3'b000};
        return (old & ~mask) | (ins & mask);
    endfunction
`endif

    // Request acceptance and alignment/size legality decode.
    always_comb begin
        accept_s = bus.req_valid && (state_r == ST_IDLE);
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
        case (bus.req_size)
            2'b00:   req_err_s = 1'b0;
            2'b01:   req_err_s = bus.req_addr[0];
            2'b10:   req_err_s = (bus.req_addr[1:0] != 2'b00);
            default: req_err_s = 1'b1;
        endcase
        store_word_s = bus.req_we && (bus.req_size == 2'b10);
`else
        req_err_s    = (bus.req_size != 2'b10) || (bus.req_addr[1:0] != 2'b00);
        store_word_s = bus.req_we;
`endif
    end

    // Next-state logic; sub-word stores read first, then write the merged word.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_nxt_s = ST_RESP;
                end else if (store_word_s) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RD:   state_nxt_s = ST_RDW;
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
            ST_RDW:  state_nxt_s = we_r ? ST_WR : ST_RESP;
`else
            ST_RDW:  state_nxt_s = ST_RESP;
`endif
            ST_WR:   state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Load result formatting from the word returned by the RAM.
    always_comb begin
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
        load_data_s = lane_extract(bus.ram_dout, size_r, lane_r, uns_r);
`else
        load_data_s = bus.ram_dout;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
    // Request fields needed after acceptance for extraction and merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            lane_r  <= 2'b00;
            wdata_r <= 16'h0000;
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            size_r  <= bus.req_size;
            uns_r   <= bus.req_unsigned;
            lane_r  <= bus.req_addr[1:0];
            wdata_r <= bus.req_wdata[15:0];
        end
    end
`endif

    // RAM port and response registers; response fields only change on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_r   <= 32'h0000_0000;
            ram_din_r    <= 32'h0000_0000;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (req_err_s) begin
                            resp_rdata_r <= 32'h0000_0000;
                            resp_err_r   <= 1'b1;
                        end else begin
                            ram_addr_r <= {2'b00, bus.req_addr[31:2]};
                            if (store_word_s) begin
                                ram_din_r <= bus.req_wdata;
                            end
                        end
                    end
                end
                ST_RDW: begin
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
                    if (we_r) begin
                        ram_din_r <= lane_merge(bus.ram_dout, wdata_r, size_r, lane_r);
                    end else begin
                        resp_rdata_r <= load_data_s;
                        resp_err_r   <= 1'b0;
                    end
`else
                    resp_rdata_r <= load_data_s;
                    resp_err_r   <= 1'b0;
`endif
                end
                ST_WR: begin
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = (state_r == ST_RESP);
    assign bus.ram_we     = (state_r == ST_WR);
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_din    = ram_din_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  pipeline MEM-stage access request.
REQ-005 req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready at a rising edge.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result, valid with resp_valid.
REQ-013 resp_err  out  1  error flag, valid with resp_valid.
REQ-014 ram_we  out  1  word-RAM write enable.
REQ-015 ram_addr  out  32  word address = {2'b00, req_addr[31:2]}.
REQ-016 ram_din  out  32  word-RAM write data.
REQ-017 ram_dout  in  32  word-RAM read data, valid in the cycle after ram_addr is presented.

Function
REQ-018 The FSM SHALL use the states IDLE, RD, RDW, WR, and RESP.
REQ-019 All req_* fields SHALL be latched on acceptance, and req_* SHALL be ignored outside IDLE.
REQ-020 Error request: size 11, half with addr[0]=1, or word with addr[1:0]!=0 SHALL go IDLE->RESP with no RAM access, resp_err=1, and resp_rdata=0.
REQ-021 Load: IDLE->RD->RDW->RESP->IDLE.
- ram_addr is driven in RD and RDW.
- ram_dout is captured at the end of RDW.
- resp_valid is asserted in the 3rd cycle after acceptance.
REQ-022 Word store: IDLE->WR->RESP->IDLE.
- ram_we=1 for exactly the WR cycle, with ram_din=req_wdata.
- resp_valid is asserted in the 2nd cycle after acceptance.
REQ-023 Sub-word store: IDLE->RD->RDW->WR->RESP->IDLE.
- The old word is captured at the end of RDW.
- The addressed byte/half lanes are replaced by req_wdata[7:0]/[15:0]; the other lanes are preserved.
- resp_valid is asserted in the 4th cycle after acceptance.
REQ-024 Byte lanes SHALL be little-endian, with lane index = addr[1:0] and the half lane selected by addr[1].
REQ-025 Loads SHALL extract the addressed lane into bits [7:0]/[15:0] and fill the upper bits with zero or the lane MSB per req_unsigned.
REQ-026 Stores SHALL return resp_rdata=0.
REQ-027 ram_we SHALL be 0 in every state except WR, and ram_addr/ram_din SHALL hold their last values when unused.
REQ-028 resp_valid SHALL be high only in RESP.
REQ-029 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-030 req_ready SHALL be 0 in RESP; a new request SHALL be accepted no earlier than the cycle after RESP, giving zero overlap between transactions.
REQ-031 Address 0xFFFFFFFC (word) SHALL map to ram_addr 0x3FFFFFFF with no wrap or error; range checking is the RAM's responsibility.

Reset
REQ-032 While rst_n=0, the block SHALL hold the FSM in IDLE with all outputs at their reset values, asynchronously:
- req_ready=1
- resp_valid=0, resp_rdata=0, resp_err=0
- ram_we=0, ram_addr=0, ram_din=0
REQ-033 Reset asserted mid-transaction SHALL abort that transaction.
- ram_we drops immediately.
- No resp_valid is produced for the aborted request.
- The first request after reset release behaves as from power-up.

Configuration
REQ-034 With MEM_ACCESS_UNIT_SUBWORD_EN defined, byte and half accesses (loads and RMW stores) SHALL behave per REQ-021..REQ-025.
REQ-035 Without MEM_ACCESS_UNIT_SUBWORD_EN, any req_size other than 10 SHALL be treated as an error per REQ-020 (no RAM access, resp_err=1), and the RMW merge logic SHALL be absent.

Verification
REQ-036 Word load: RAM word 3 = 0x11223344; load word addr 0x0C -> ram_addr=3, resp_valid in the 3rd cycle, resp_rdata=0x11223344, resp_err=0.
REQ-037 Signed/unsigned byte load: RAM word 1 = 0x80FF7F01; load byte addr 0x06 signed -> 0xFFFFFFFF; load byte addr 0x06 unsigned -> 0x000000FF; load byte addr 0x07 signed -> 0xFFFFFF80.
REQ-038 Half store RMW: word 2 = 0xAABBCCDD; store half addr 0x0A, wdata 0x12345678 -> a single ram_we pulse with ram_din=0x5678CCDD; resp_valid in the 4th cycle.
REQ-039 Misaligned access: word load at addr 0x02 -> ram_we never asserted, ram_addr unchanged, resp_valid in the next cycle, resp_err=1, resp_rdata=0.
REQ-040 Reset mid-store: rst_n low during RDW of a byte store -> ram_we stays 0, no resp_valid, req_ready=1 immediately; a following word store behaves per REQ-022.
REQ-041 Back-to-back: req_valid held high with two loads -> second accepted only after RESP; req_ready=0 throughout; no overlap of RAM accesses.
